// File: rtl/cnn_seq_pkg.sv
// Shared types and defaults for the CNN layer sequencer: FSM states, counter ops,
// and a helper that derives the fixed-latency layer mask from a layer-type list.
package cnn_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_HI,
      S_WAIT_LO,
      S_FUNC,
      S_FUNC_WAIT,
      S_NEXT
   } seq_state_t;

   typedef enum logic [1:0] {
      CNT_HOLD,
      CNT_LOAD,
      CNT_UP,
      CNT_DOWN
   } cnt_op_t;

   typedef enum logic [1:0] {
      LT_CONV,
      LT_POOL,
      LT_FC
   } layer_type_t;

   localparam int DEF_NUM_LAYERS   = 5;
   localparam int DEF_FIXED_LAT    = 16;
   localparam int DEF_FUNC_LAT     = 4;
   localparam int DEF_BUSY_TIMEOUT = 64;
   localparam int DEF_CNT_WIDTH    = 16;

   // Two bits per layer, layer 0 in the least significant slot.
   function automatic logic [31:0] mask_from_types(input logic [63:0] types, input int n);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < n && i < 32; i++)
         m[i] = (types[2*i +: 2] == LT_POOL);
      return m;
   endfunction

   localparam logic [63:0] DEF_LAYER_TYPES = 64'({LT_FC, LT_FC, LT_FC, LT_POOL, LT_CONV});
   localparam logic [DEF_NUM_LAYERS-1:0] DEF_FIXED_LAT_MASK =
      DEF_NUM_LAYERS'(mask_from_types(DEF_LAYER_TYPES, DEF_NUM_LAYERS));

endpackage

// File: rtl/seq_wait_counter.sv
// Loadable up/down wait counter with a terminal-count compare, shared by the
// busy-rise timeout, fixed-latency wait and func wait phases of the sequencer.
module seq_wait_counter
   import cnn_seq_pkg::*;
#(
   parameter int cnt_width = DEF_CNT_WIDTH
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           op,
   input  logic [cnt_width-1:0] load_val,
   input  logic [cnt_width-1:0] term_val,
   output logic [cnt_width-1:0] count,
   output logic                 tc
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else begin
         case (cnt_op_t'(op))
            CNT_LOAD: count <= load_val;
            CNT_UP:   count <= count + cnt_width'(1);
            CNT_DOWN: count <= count - cnt_width'(1);
            default:  count <= count;
         endcase
      end
   end

   assign tc = (count == term_val);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Runs one inference through the CNN layer chain, one layer at a time, issuing
// start/func_start pulses and following each layer's busy handshake.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   IDLE        | waiting for i_run
//   START       | o_start[idx] pulse; fixed layers load fixed_lat
//   WAIT_HI     | waiting for busy to rise, timeout after busy_timeout
//   WAIT_LO     | busy layer: wait for busy low; fixed layer: count down
//   FUNC        | o_func_start[idx] pulse; load func_lat
//   FUNC_WAIT   | count down func_lat
//   NEXT        | advance idx, or pulse o_done after the last layer
module cnn_layer_sequencer
   import cnn_seq_pkg::*;
#(
   parameter int                    num_layers     = DEF_NUM_LAYERS,
   parameter logic [num_layers-1:0] fixed_lat_mask = DEF_FIXED_LAT_MASK,
   parameter int                    fixed_lat      = DEF_FIXED_LAT,
   parameter int                    func_lat       = DEF_FUNC_LAT,
   parameter int                    busy_timeout   = DEF_BUSY_TIMEOUT,
   parameter int                    cnt_width      = DEF_CNT_WIDTH,
   localparam int                   idx_width      = (num_layers > 1) ? $clog2(num_layers) : 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_run,
   input  logic                  i_abort,
   input  logic [num_layers-1:0] i_layer_busy,
   output logic [num_layers-1:0] o_start,
   output logic [num_layers-1:0] o_func_start,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic [idx_width-1:0]  o_layer_idx
);

   localparam logic [idx_width-1:0]  last_idx = idx_width'(num_layers - 1);
   localparam logic [num_layers-1:0] lay_one  = num_layers'(1);

   seq_state_t             state, state_nxt;
   logic [idx_width-1:0]   idx, idx_nxt;
   logic                   err_nxt;
   cnt_op_t                cnt_op;
   logic [cnt_width-1:0]   cnt_load, cnt_term, count;
   logic                   cnt_tc;
   logic                   lay_busy, lay_fixed;
   logic [num_layers-1:0]  start_nxt, func_nxt;
   logic                   done_nxt;

   assign lay_busy  = i_layer_busy[idx];
   assign lay_fixed = fixed_lat_mask[idx];
   assign cnt_term  = (state == S_WAIT_HI) ? cnt_width'(busy_timeout - 1) : cnt_width'(1);

   seq_wait_counter #(.cnt_width(cnt_width)) u_wait_counter (
      .clk      (clk),
      .rst      (rst),
      .op       (cnt_op),
      .load_val (cnt_load),
      .term_val (cnt_term),
      .count    (count),
      .tc       (cnt_tc)
   );

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      err_nxt   = o_error;
      cnt_op    = CNT_HOLD;
      cnt_load  = '0;
      case (state)
         S_IDLE: begin
            cnt_op = CNT_LOAD;
            if (i_run) begin
               state_nxt = S_START;
               idx_nxt   = '0;
               err_nxt   = 1'b0;
            end
         end
         S_START: begin
            if (lay_fixed) begin
               cnt_op    = CNT_LOAD;
               cnt_load  = cnt_width'(fixed_lat);
               state_nxt = S_WAIT_LO;
            end else begin
               cnt_op    = CNT_UP;
               state_nxt = S_WAIT_HI;
            end
         end
         S_WAIT_HI: begin
            cnt_op = CNT_UP;
            if (lay_busy) begin
               state_nxt = S_WAIT_LO;
            end else if (cnt_tc) begin
               err_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_WAIT_LO: begin
            if (lay_fixed) begin
               cnt_op = CNT_DOWN;
               if (cnt_tc) state_nxt = S_FUNC;
            end else if (!lay_busy) begin
               state_nxt = S_FUNC;
            end
         end
         S_FUNC: begin
            cnt_op    = CNT_LOAD;
            cnt_load  = cnt_width'(func_lat);
            state_nxt = S_FUNC_WAIT;
         end
         S_FUNC_WAIT: begin
            cnt_op = CNT_DOWN;
            if (cnt_tc) state_nxt = S_NEXT;
         end
         S_NEXT: begin
            cnt_op = CNT_LOAD;
            if (idx == last_idx) begin
               state_nxt = S_IDLE;
            end else begin
               idx_nxt   = idx + idx_width'(1);
               state_nxt = S_START;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // Abort overrides everything except the sticky error flag.
      if (i_abort) begin
         state_nxt = S_IDLE;
         idx_nxt   = '0;
         err_nxt   = o_error;
         cnt_op    = CNT_LOAD;
         cnt_load  = '0;
      end

      start_nxt = (state_nxt == S_START) ? (lay_one << idx_nxt) : '0;
      func_nxt  = (state_nxt == S_FUNC)  ? (lay_one << idx_nxt) : '0;
      done_nxt  = (state_nxt == S_NEXT) && (idx_nxt == last_idx);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         idx          <= '0;
         o_error      <= 1'b0;
         o_start      <= '0;
         o_func_start <= '0;
         o_done       <= 1'b0;
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         o_error      <= err_nxt;
         o_start      <= start_nxt;
         o_func_start <= func_nxt;
         o_done       <= done_nxt;
      end
   end

   assign o_busy      = (state != S_IDLE);
   assign o_layer_idx = idx;

endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
- Sequences one inference through the chain of CNN layers: conv, pool, then the FC layers.
- Issues per-layer start and func_start pulses and tracks each layer's busy handshake.
- Advances to the next layer only when the current one has finished.
- Sits beside the generated CNN top and drives its i_start_N / i_func_start_N inputs from its o_busy_N outputs. Only one layer is active at a time (non-pipelined scheduling).

Parameters:
- num_layers, 5, number of layers sequenced; layer index 0 is first.
- fixed_lat_mask, 5'b00010, bit k=1: layer k has no busy output (pool) and completes after fixed_lat cycles.
- fixed_lat, 16, cycles a fixed-latency layer is considered busy after its start pulse.
- func_lat, 4, cycles allowed between a func_start pulse and the next layer's start.
- busy_timeout, 64, max cycles to wait for busy to rise after start before flagging an error.
- cnt_width, 16, width of the internal wait counter; must satisfy 2^cnt_width > max(fixed_lat, func_lat, busy_timeout).

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-low reset.
- i_run, input, 1, one-cycle request to start an inference; accepted only in IDLE.
- i_abort, input, 1, synchronous abort; returns the block to IDLE.
- i_layer_busy, input, [num_layers-1:0], o_busy of each layer; bits set in fixed_lat_mask are ignored.
- o_start, output, [num_layers-1:0], one-hot, one-cycle start pulse per layer.
- o_func_start, output, [num_layers-1:0], one-hot, one-cycle func_start pulse per layer.
- o_busy, output, 1, high in every state except IDLE.
- o_done, output, 1, one-cycle pulse when the last layer's func phase completes.
- o_error, output, 1, sticky busy-timeout flag; cleared by the next accepted i_run or by reset.
- o_layer_idx, output, $clog2(num_layers), index of the active layer.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, layer index=0, counter=0.
  - All outputs 0.
- States: IDLE, START, WAIT_HI, WAIT_LO, FUNC, FUNC_WAIT, NEXT.
- IDLE: on i_run=1, go to START, clear o_error, set idx=0. Otherwise stay.
- START:
  - o_start[idx]=1 for exactly this cycle; counter cleared.
  - If fixed_lat_mask[idx], go to WAIT_LO with counter loaded to fixed_lat; else go to WAIT_HI.
- WAIT_HI:
  - Counter increments each cycle.
  - i_layer_busy[idx]=1 → WAIT_LO.
  - Counter reaching busy_timeout-1 with busy still 0 → set o_error, go to IDLE without o_done.
- WAIT_LO:
  - Fixed-latency layer: counter decrements; at 1 → FUNC. The layer therefore occupies fixed_lat cycles in WAIT_LO.
  - Busy-driven layer: i_layer_busy[idx]=0 → FUNC.
- FUNC: o_func_start[idx]=1 for exactly this cycle; counter loaded to func_lat → FUNC_WAIT.
- FUNC_WAIT: counter decrements; at 1 → NEXT.
- NEXT:
  - If idx==num_layers-1: o_done=1 this cycle, go to IDLE.
  - Else: idx+1 → START.
- Latency per layer: 1 (START) + WAIT_HI cycles + WAIT_LO cycles + 1 (FUNC) + func_lat + 1 (NEXT).
- o_start and o_func_start are registered, and never both non-zero in the same cycle.
- i_run outside IDLE is ignored; no queuing.
- i_abort has priority over all transitions:
  - Next state is IDLE and idx=0.
  - Any pulse that would have been generated this cycle is suppressed; o_done is not asserted.
  - o_error is unchanged.
- i_abort and i_run in the same cycle in IDLE: abort wins, no start.
- Busy that is already high at START (a stale layer) passes WAIT_HI immediately. The bench checks that no layer is busy before i_run.
- Reset mid-operation: immediate return to the reset values above; no partial pulses are emitted after rst deasserts.

Decomposition:
- Package cnn_seq_pkg:
  - enum seq_state_t.
  - Constant defaults for fixed_lat, func_lat, busy_timeout.
  - Function to build fixed_lat_mask from a layer-type list.
- One sub-module is natural: seq_wait_counter, a loadable up/down counter with a terminal-count flag, shared by WAIT_HI, WAIT_LO and FUNC_WAIT.

Test Plan:
- Nominal run (defaults): i_run pulse; each busy layer raises busy 2 cycles after its start and holds it 10 cycles.
  - o_start pulses in order 0,1,2,3,4; o_start[1] is followed by o_func_start[1] exactly 17 cycles later.
  - o_done pulses once; o_busy falls the cycle after o_done.
- Timeout: layer 2 never raises busy.
  - o_error rises 64 cycles after o_start[2]; state returns to IDLE; o_start[3] never asserts; o_done stays 0.
- Abort: assert i_abort while layer 3 is in WAIT_LO.
  - Next cycle o_busy=0 and o_layer_idx=0; no o_func_start[3] is issued.
  - A subsequent i_run restarts from layer 0.
- Ignored run: pulse i_run during layer 1 → no effect; the sequence completes identically with exactly one o_done.
- Async reset: assert rst=0 mid-FUNC_WAIT of layer 4 → all outputs 0 without waiting for a clock edge; after release the block stays IDLE until i_run.
- Simultaneous events: i_run and i_abort together in IDLE → no o_start. Then an i_run alone → o_start[0] asserts on the following cycle.
